// File: rtl/logo_anim_painter_if.sv
// Pixel/animation bus between the VGA timing side and logo_anim_painter.
interface logo_anim_painter_if #(
  parameter int unsigned NUM_GLYPHS = 4
);
  logic                      enable;
  logic                      frame_start;
  logic [10:0]               x;
  logic [10:0]               y;
  logic [2*NUM_GLYPHS-1:0]   glyph_sel;
  logic                      hit;
  logic [10:0]               delt;
  logic                      dir_left;

  modport master (
    output enable, frame_start, x, y, glyph_sel,
    input  hit, delt, dir_left
  );

  modport slave (
    input  enable, frame_start, x, y, glyph_sel,
    output hit, delt, dir_left
  );
endinterface

// File: rtl/logo_anim_painter.sv
// Paints a row of Z/N/L stroke glyphs with a per-frame horizontal bounce.
// Optional blink (visibility toggled every BLINK_FRAMES frames) under `LOGO_BLINK_EN.
module logo_anim_painter #(
  parameter int unsigned NUM_GLYPHS      = 4,
  parameter int unsigned SIZE            = 40,
  parameter int unsigned STROKE          = 5,
  parameter int unsigned GAP             = 10,
  parameter int unsigned BASE_X          = 500,
  parameter int unsigned BASE_Y          = 550,
  parameter int unsigned SPAN            = 100,
  parameter int unsigned STEP            = 2,
  parameter int unsigned FRAMES_PER_STEP = 1,
  parameter int unsigned PAUSE_FRAMES    = 30
`ifdef LOGO_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES    = 32
`endif
) (
  input logic                clk,
  input logic                rst,
  logo_anim_painter_if.slave bus
);

  localparam int unsigned PITCH = SIZE + STROKE + GAP;
  localparam int unsigned FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned PC_W  = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'((FRAMES_PER_STEP > 1) ? FRAMES_PER_STEP - 1 : 0);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'((PAUSE_FRAMES > 1) ? PAUSE_FRAMES - 1 : 0);
  localparam logic [11:0] C_S  = 12'(SIZE);
  localparam logic [11:0] C_W  = 12'(STROKE);
  localparam logic [11:0] C_SW = 12'(SIZE + STROKE);

  typedef enum logic [1:0] {S_RIGHT, S_HOLD_R, S_LEFT, S_HOLD_L} state_t;

  state_t          state, state_nxt;
  logic [10:0]     delt, delt_nxt;
  logic            dir_left, dir_nxt;
  logic [FC_W-1:0] frame_cnt, frame_nxt;
  logic [PC_W-1:0] pause_cnt, pause_nxt;
  logic            hit, hit_nxt;
  logic            visible;

  logic fs_en, step, hold_done, at_top, at_bot;
  logic [NUM_GLYPHS-1:0] slot_hit;

  assign fs_en     = bus.frame_start & bus.enable;
  assign step      = fs_en & (frame_cnt == FC_MAX);
  assign hold_done = fs_en & (pause_cnt == PC_MAX);
  assign at_top    = (12'(delt) + 12'(STEP)) >= 12'(SPAN);
  assign at_bot    = delt <= 11'(STEP);

  // Per-slot stroke test; dx/dy negative means the pixel is above/left of the box.
  for (genvar g = 0; g < NUM_GLYPHS; g++) begin : g_slot
    localparam int unsigned OFF = BASE_X + g * PITCH;
    logic [11:0] dx, dy, ux, uy, sum, diff;
    logic [1:0]  code;
    logic        inb, z_hit, n_hit, l_hit;

    assign dx   = 12'(bus.x) - 12'(OFF) - 12'(delt);
    assign dy   = 12'(bus.y) - 12'(BASE_Y);
    assign inb  = ~dx[11] & ~dy[11];
    assign ux   = {1'b0, dx[10:0]};
    assign uy   = {1'b0, dy[10:0]};
    assign sum  = ux + uy;
    assign diff = ux - uy;
    assign code = bus.glyph_sel[2*g +: 2];

    assign z_hit = ((ux < C_S) && (uy < C_W)) ||
                   ((ux < C_S) && (uy >= C_S) && (uy < C_SW)) ||
                   ((sum >= C_S) && (sum < C_SW) && (uy < C_S));
    assign n_hit = (uy < C_SW) &&
                   ((ux < C_W) || ((ux >= C_S) && (ux < C_SW)) ||
                    ((ux >= uy) && (diff < C_W)));
    assign l_hit = ((ux < C_W) && (uy < C_SW)) ||
                   ((ux < C_SW) && (uy >= C_S) && (uy < C_SW));

    always_comb begin
      slot_hit[g] = 1'b0;
      if (inb) begin
        case (code)
          2'd1:    slot_hit[g] = z_hit;
          2'd2:    slot_hit[g] = n_hit;
          2'd3:    slot_hit[g] = l_hit;
          default: slot_hit[g] = 1'b0;
        endcase
      end
    end
  end

`ifdef LOGO_BLINK_EN
  localparam int unsigned BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] BC_MAX = BC_W'((BLINK_FRAMES > 1) ? BLINK_FRAMES - 1 : 0);
  logic [BC_W-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (fs_en) begin
      if (blink_cnt == BC_MAX) begin
        blink_cnt <= '0;
        visible   <= ~visible;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end
`else
  assign visible = 1'b1;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RIGHT;
      delt      <= '0;
      dir_left  <= 1'b0;
      frame_cnt <= '0;
      pause_cnt <= '0;
      hit       <= 1'b0;
    end else begin
      state     <= state_nxt;
      delt      <= delt_nxt;
      dir_left  <= dir_nxt;
      frame_cnt <= frame_nxt;
      pause_cnt <= pause_nxt;
      hit       <= hit_nxt;
    end
  end

  // Bounce sequencing; a zero hold skips straight to the opposite run.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RIGHT: if (step && at_top) state_nxt = (PAUSE_FRAMES == 0) ? S_LEFT : S_HOLD_R;
      S_HOLD_R: if (hold_done) state_nxt = S_LEFT;
      S_LEFT:  if (step && at_bot) state_nxt = (PAUSE_FRAMES == 0) ? S_RIGHT : S_HOLD_L;
      S_HOLD_L: if (hold_done) state_nxt = S_RIGHT;
      default: state_nxt = S_RIGHT;
    endcase
  end

  // Offset, counters and pixel hit for the next cycle.
  always_comb begin
    delt_nxt  = delt;
    frame_nxt = frame_cnt;
    pause_nxt = pause_cnt;
    case (state)
      S_RIGHT, S_LEFT: begin
        if (fs_en) frame_nxt = step ? '0 : frame_cnt + FC_W'(1);
        if (step) begin
          if (state == S_RIGHT) delt_nxt = at_top ? 11'(SPAN) : delt + 11'(STEP);
          else                  delt_nxt = at_bot ? 11'd0     : delt - 11'(STEP);
        end
      end
      default: begin
        if (fs_en) pause_nxt = hold_done ? '0 : pause_cnt + PC_W'(1);
      end
    endcase
    dir_nxt = (state_nxt == S_HOLD_R) || (state_nxt == S_LEFT);
    hit_nxt = bus.enable & visible & (|slot_hit);
  end

  assign bus.hit      = hit;
  assign bus.delt     = delt;
  assign bus.dir_left = dir_left;

endmodule

// File: tb/tb_logo_anim_painter.sv
// Scoreboard bench for logo_anim_painter: glyph geometry, bounce, hold, enable and reset.
module tb_logo_anim_painter;

  localparam int NG = 4, S = 40, W = 5, BX = 500, BY = 550, PITCH = 55;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logo_anim_painter_if #(.NUM_GLYPHS(NG)) bus ();
  logo_anim_painter dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    string tag;
    int    kind;   // 0 hit, 1 delt, 2 dir_left
    int    exp;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  e_delt   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int model_hit(input int px, input int py, input logic [7:0] sel, input int d);
    int h = 0;
    for (int i = 0; i < NG; i++) begin
      int ox, dx, dy, code;
      ox   = BX + d + i * PITCH;
      dx   = px - ox;
      dy   = py - BY;
      code = int'(sel[2*i +: 2]);
      if (dx >= 0 && dy >= 0) begin
        case (code)
          1: if ((dy < W && dx < S) || (dy >= S && dy < S + W && dx < S) ||
                 (dy < S && dx + dy >= S && dx + dy < S + W)) h = 1;
          2: if (dy < S + W && (dx < W || (dx >= S && dx < S + W) ||
                 (dx - dy >= 0 && dx - dy < W))) h = 1;
          3: if ((dx < W && dy < S + W) || (dy >= S && dy < S + W && dx < S + W)) h = 1;
          default: ;
        endcase
      end
    end
    return h;
  endfunction

  // Advance one clock and retire every expectation queued for the previous inputs.
  task automatic step_cycle();
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      case (e.kind)
        0:       check(e.tag, int'(bus.hit), e.exp);
        1:       check(e.tag, int'(bus.delt), e.exp);
        default: check(e.tag, int'(bus.dir_left), e.exp);
      endcase
    end
  endtask

  task automatic px(input int xx, input int yy, input string tag);
    int exp;
    bus.x = 11'(xx);
    bus.y = 11'(yy);
    exp = bus.enable ? model_hit(xx, yy, bus.glyph_sel, e_delt) : 0;
    sb.push_back('{tag, 0, exp});
    step_cycle();
  endtask

  task automatic pulse(input int exp_delt, input int exp_dir, input string tag);
    bus.frame_start = 1'b1;
    sb.push_back('{{tag, "_delt"}, 1, exp_delt});
    sb.push_back('{{tag, "_dir"}, 2, exp_dir});
    step_cycle();
    bus.frame_start = 1'b0;
    e_delt = exp_delt;
  endtask

  initial begin
    rst             = 1'b1;
    bus.enable      = 1'b0;
    bus.frame_start = 1'b0;
    bus.x           = '0;
    bus.y           = '0;
    bus.glyph_sel   = 8'b11_00_10_01;  // slot3 L, slot2 blank, slot1 N, slot0 Z
    step_cycle();
    sb.push_back('{"rst_hit", 0, 0});
    sb.push_back('{"rst_delt", 1, 0});
    sb.push_back('{"rst_dir", 2, 0});
    step_cycle();
    rst        = 1'b0;
    bus.enable = 1'b1;

    // Glyph geometry at delt = 0
    px(500, 550, "z_top");
    px(530, 560, "z_diag");
    px(520, 560, "z_hole");
    px(499, 550, "z_left_edge");
    px(555, 570, "n_left");
    px(575, 590, "n_575_590");
    px(575, 570, "n_diag");
    px(600, 560, "n_past_right");
    px(599, 560, "n_right");
    for (int xx = 610; xx <= 654; xx += 4) px(xx, 560, "blank_slot");
    px(665, 589, "l_left");
    px(700, 590, "l_bottom");
    px(710, 590, "l_past");
    for (int k = 0; k < 40; k++)
      px(int'($urandom_range(760, 480)), int'($urandom_range(600, 540)), "rand_px");

    // Rightward run
    for (int j = 1; j <= 10; j++) pulse(2 * j, 0, "run_r");
    px(520, 550, "shift_hit");
    px(519, 550, "shift_miss");
    for (int j = 11; j <= 50; j++) pulse((2 * j > 100) ? 100 : 2 * j, (j >= 50) ? 1 : 0, "run_r2");

    // Right-end hold then first left step
    for (int j = 1; j <= 30; j++) pulse(100, 1, "hold_r");
    pulse(98, 1, "left1");

    // Freeze while disabled
    bus.enable = 1'b0;
    for (int j = 0; j < 20; j++) pulse(98, 1, "frozen");
    px(598, 550, "dis_hit");
    bus.enable = 1'b1;
    px(598, 550, "reen_hit");

    // Continue left to 60, then reset coincident with frame_start
    for (int j = 1; j <= 19; j++) pulse(98 - 2 * j, 1, "run_l");
    bus.x           = 11'(560);
    bus.y           = 11'(550);
    rst             = 1'b1;
    bus.frame_start = 1'b1;
    sb.push_back('{"rst2_hit", 0, 0});
    sb.push_back('{"rst2_delt", 1, 0});
    sb.push_back('{"rst2_dir", 2, 0});
    step_cycle();
    rst             = 1'b0;
    bus.frame_start = 1'b0;
    e_delt          = 0;
    pulse(2, 0, "post_rst");
    px(502, 550, "post_rst_hit");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
